// File: rtl/instruction_fetch_controller.sv
// ============================================================================
// Module  : instruction_fetch_controller
// Purpose : Drives the instruction memory address, captures each word, and
//           presents it to decode over valid/ready, with branch and halt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_controller #(
    parameter int                    ADDRESS_WIDTH  = 8,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    PROGRAM_LENGTH = 6,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE    = 8'hFF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0]    instruction_data,
    output logic [DATA_WIDTH-1:0]    fetched_instruction,
    output logic [ADDRESS_WIDTH-1:0] fetched_address,
    output logic                     fetched_valid,
    input  logic                     fetched_ready,
    input  logic                     branch_valid,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    output logic                     busy,
    output logic                     halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS   = ADDRESS_WIDTH'(PROGRAM_LENGTH - 1);
    localparam logic [ADDRESS_WIDTH:0]   PROGRAM_EXTENT = (ADDRESS_WIDTH + 1)'(PROGRAM_LENGTH);

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0]    instruction_next;
    logic [ADDRESS_WIDTH-1:0] address_next;
    logic                     valid_next;
    logic [ADDRESS_WIDTH-1:0] pc_successor;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     output_free;

    assign pc_successor = (pc == LAST_ADDRESS) ? '0 : pc + 1'b1;
    // Out-of-range branch targets restart the program rather than fetching garbage.
    assign redirect_pc  = ({1'b0, branch_target} < PROGRAM_EXTENT) ? branch_target : '0;
    assign output_free  = !fetched_valid || fetched_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            pc                  <= '0;
            fetched_instruction <= '0;
            fetched_address     <= '0;
            fetched_valid       <= 1'b0;
        end else begin
            state               <= state_next;
            pc                  <= pc_next;
            fetched_instruction <= instruction_next;
            fetched_address     <= address_next;
            fetched_valid       <= valid_next;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instruction_next = fetched_instruction;
        address_next     = fetched_address;
        valid_next       = fetched_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (branch_valid) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                end else if (output_free) begin
                    instruction_next = instruction_data;
                    address_next     = pc;
                    valid_next       = 1'b1;
                    // The halt word is still presented; pc stays on it.
                    if (instruction_data == HALT_OPCODE) begin
                        state_next = HALTED;
                    end else begin
                        pc_next = pc_successor;
                    end
                end
            end
            HALTED: begin
                if (fetched_valid) begin
                    if (fetched_ready) begin
                        valid_next = 1'b0;
                    end
                end else if (start) begin
                    pc_next    = '0;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign instruction_address = pc;
    assign busy                = (state == RUN);
    assign halted              = (state == HALTED);

endmodule

`default_nettype wire
